preamble_sync_ctrl: RTL and testbench



---
 rtl/sync_pkg.sv | 17 +
 rtl/cr_mag.sv | 24 ++
 rtl/preamble_sync_ctrl.sv | 163 ++++++++++++++++
 tb/tb_preamble_sync_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared types, default geometry and helpers for the 802.16 preamble sync controller.
package sync_pkg;

  typedef enum logic [2:0] {IDLE, SEARCH, PEAK, ALIGN, TRACK} state_t;

  localparam int unsigned DEF_CR_W     = 7;
  localparam int unsigned DEF_MAG_W    = 8;
  localparam int unsigned DEF_PEAK_WIN = 16;
  localparam int unsigned DEF_SYM_DLY  = 256;
  localparam int unsigned DEF_SYM_LEN  = 320;

  // Caller sign-extends into int; the most negative input maps to its positive magnitude.
  function automatic int abs_ext(input int x);
    return (x < 0) ? -x : x;
  endfunction

endpackage

// File: rtl/cr_mag.sv
// Registered |Re|+|Im| of the correlator output, loaded only on qualified samples.
module cr_mag
  import sync_pkg::*;
#(
  parameter int unsigned CR_W  = DEF_CR_W,
  parameter int unsigned MAG_W = DEF_MAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [CR_W-1:0] re,
  input  logic signed [CR_W-1:0] im,
  output logic [MAG_W-1:0]       mag
);

  always_ff @(posedge clk) begin
    if (rst) begin
      mag <= '0;
    end else if (en) begin
      mag <= MAG_W'(abs_ext(int'(re))) + MAG_W'(abs_ext(int'(im)));
    end
  end

endmodule

// File: rtl/preamble_sync_ctrl.sv
// Preamble correlator sequencer: peak search in a qualified-sample window, then
// symbol-boundary strobes for the remainder of the frame.
module preamble_sync_ctrl
  import sync_pkg::*;
#(
  parameter int unsigned CR_W     = DEF_CR_W,
  parameter int unsigned MAG_W    = DEF_MAG_W,
  parameter int unsigned PEAK_WIN = DEF_PEAK_WIN,
  parameter int unsigned SYM_DLY  = DEF_SYM_DLY,
  parameter int unsigned SYM_LEN  = DEF_SYM_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [MAG_W-1:0]       thresh,
  input  logic [7:0]             n_sym,
  input  logic signed [CR_W-1:0] CR_in_Re,
  input  logic signed [CR_W-1:0] CR_in_Im,
  output logic                   corr_ena,
  output logic                   sync_found,
  output logic [MAG_W-1:0]       peak_mag,
  output logic [4:0]             peak_off,
  output logic                   sym_start,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned WC_W = $clog2(PEAK_WIN + 1);
  localparam int unsigned CD_W = $clog2(SYM_DLY + 1);
  localparam int unsigned SL_W = $clog2(SYM_LEN);

  state_t           state, state_n;
  logic [MAG_W-1:0] mag;
  logic [WC_W-1:0]  win_cnt, win_n;
  logic [MAG_W-1:0] best, best_n;
  logic [4:0]       since_pk, sp_n;
  logic [CD_W-1:0]  cd, cd_n;
  logic [SL_W-1:0]  sl_cnt, sl_n;
  logic [7:0]       sym_cnt, symc_n;
  logic [7:0]       n_sym_q, nsym_n;
  logic [MAG_W-1:0] pmag_n;
  logic [4:0]       poff_n;
  logic             sf_n, ss_n, fd_n;

  cr_mag #(.CR_W(CR_W), .MAG_W(MAG_W)) u_mag (
    .clk (clk),
    .rst (rst),
    .en  (en_in),
    .re  (CR_in_Re),
    .im  (CR_in_Im),
    .mag (mag)
  );

  assign corr_ena = en_in & ((state == SEARCH) | (state == PEAK));
  assign busy     = (state != IDLE);

  // Each qualified edge consumes the sample held in mag (accepted on the previous qualified edge).
  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    best_n  = best;
    sp_n    = since_pk;
    cd_n    = cd;
    sl_n    = sl_cnt;
    symc_n  = sym_cnt;
    nsym_n  = n_sym_q;
    pmag_n  = peak_mag;
    poff_n  = peak_off;
    sf_n    = 1'b0;
    ss_n    = 1'b0;
    fd_n    = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (arm) state_n = SEARCH;
        SEARCH: if (en_in && (mag >= thresh)) begin
          best_n  = mag;
          sp_n    = '0;
          win_n   = WC_W'(1);
          state_n = PEAK;
        end
        PEAK: if (en_in) begin
          if (mag > best) begin
            best_n = mag;
            sp_n   = '0;
          end else begin
            sp_n = since_pk + 5'd1;
          end
          win_n = win_cnt + WC_W'(1);
          if (win_cnt == WC_W'(PEAK_WIN - 1)) begin
            sf_n    = 1'b1;
            pmag_n  = best_n;
            poff_n  = 5'(PEAK_WIN - 1) - sp_n;
            nsym_n  = n_sym;
            cd_n    = CD_W'(SYM_DLY - 1) - CD_W'(sp_n);
            state_n = ALIGN;
          end
        end
        ALIGN: if (en_in) begin
          if (cd == '0) begin
            ss_n    = 1'b1;
            symc_n  = 8'd1;
            sl_n    = SL_W'(SYM_LEN - 1);
            state_n = TRACK;
          end else begin
            cd_n = cd - CD_W'(1);
          end
        end
        TRACK: if (en_in) begin
          if (sl_cnt == '0) begin
            sl_n = SL_W'(SYM_LEN - 1);
            if ((n_sym_q != 8'd0) && (sym_cnt == n_sym_q)) begin
              fd_n    = 1'b1;
              state_n = arm ? SEARCH : IDLE;
            end else begin
              ss_n   = 1'b1;
              symc_n = sym_cnt + 8'd1;
            end
          end else begin
            sl_n = sl_cnt - SL_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      best       <= '0;
      since_pk   <= '0;
      cd         <= '0;
      sl_cnt     <= '0;
      sym_cnt    <= '0;
      n_sym_q    <= '0;
      peak_mag   <= '0;
      peak_off   <= '0;
      sync_found <= 1'b0;
      sym_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      win_cnt    <= win_n;
      best       <= best_n;
      since_pk   <= sp_n;
      cd         <= cd_n;
      sl_cnt     <= sl_n;
      sym_cnt    <= symc_n;
      n_sym_q    <= nsym_n;
      peak_mag   <= pmag_n;
      peak_off   <= poff_n;
      sync_found <= sf_n;
      sym_start  <= ss_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// Bench for preamble_sync_ctrl: magnitude table, directed frame sequences and
// randomized streams checked against a sample-indexed reference model.
module tb_preamble_sync_ctrl;

  localparam int PW  = 16;
  localparam int DLY = 256;
  localparam int LEN = 320;
  localparam int MAXN = 1600;

  logic              clk = 1'b0;
  logic              rst, en_in, arm, abort;
  logic [7:0]        thresh, n_sym;
  logic signed [6:0] CR_in_Re, CR_in_Im;
  logic              corr_ena, sync_found, sym_start, frame_done, busy;
  logic [7:0]        peak_mag;
  logic [4:0]        peak_off;

  preamble_sync_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en_in      (en_in),
    .arm        (arm),
    .abort      (abort),
    .thresh     (thresh),
    .n_sym      (n_sym),
    .CR_in_Re   (CR_in_Re),
    .CR_in_Im   (CR_in_Im),
    .corr_ena   (corr_ena),
    .sync_found (sync_found),
    .peak_mag   (peak_mag),
    .peak_off   (peak_off),
    .sym_start  (sym_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int acc;
  int busy_ab;
  logic signed [6:0] s_re [0:MAXN];
  logic signed [6:0] s_im [0:MAXN];
  int m [0:MAXN];
  int sf_q[$], pm_q[$], po_q[$], ss_q[$], fd_q[$];
  int e_sf[$], e_pm[$], e_po[$], e_ss[$], e_fd[$];

  typedef struct {
    logic signed [6:0] re;
    logic signed [6:0] im;
    int                mag;
  } mag_vec_t;
  mag_vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_q(input string name, input int act[$], input int exp[$]);
    chk({name, "_count"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  task automatic clr_q();
    sf_q.delete(); pm_q.delete(); po_q.delete(); ss_q.delete(); fd_q.delete();
  endtask

  // One clock; pulses seen after an edge are tagged with the consumed sample index.
  task automatic step(input logic e, input logic signed [6:0] re,
                      input logic signed [6:0] im, input logic ab);
    en_in = e; CR_in_Re = re; CR_in_Im = im; abort = ab;
    @(posedge clk); #1;
    if (e) acc++;
    if (sync_found) begin
      sf_q.push_back(acc - 2);
      pm_q.push_back(int'(peak_mag));
      po_q.push_back(int'(peak_off));
    end
    if (sym_start)  ss_q.push_back(acc - 2);
    if (frame_done) fd_q.push_back(acc - 2);
    abort = 1'b0;
  endtask

  task automatic start_scn();
    arm = 1'b0;
    step(1'b0, '0, '0, 1'b1);
    acc = 0;
    step(1'b1, s_re[0], s_im[0], 1'b0);
    arm = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    clr_q();
  endtask

  task automatic run_stream(input int n, input int duty, input int abort_at);
    for (int i = 1; i <= n; i++) begin
      for (int g = 1; g < duty; g++) step(1'b0, 7'($urandom), 7'($urandom), 1'b0);
      if (i - 1 == abort_at) begin
        arm = 1'b0;
        step(1'b1, s_re[i], s_im[i], 1'b1);
        busy_ab = int'(busy);
      end else begin
        step(1'b1, s_re[i], s_im[i], 1'b0);
      end
    end
  endtask

  task automatic fill_base(input int n, input logic signed [6:0] re, input logic signed [6:0] im);
    for (int i = 0; i <= n; i++) begin s_re[i] = re; s_im[i] = im; end
  endtask

  function automatic int amag(input logic signed [6:0] r, input logic signed [6:0] i);
    int a, b;
    a = int'(r); b = int'(i);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return a + b;
  endfunction

  // Reference: consumed samples 0..n-1 (0 = priming sample); events as sample indices.
  task automatic model(input int n, input int thr, input int ns);
    int start, t, p, idx, j;
    e_sf.delete(); e_pm.delete(); e_po.delete(); e_ss.delete(); e_fd.delete();
    for (int i = 0; i <= n; i++) m[i] = amag(s_re[i], s_im[i]);
    start = 0;
    forever begin
      t = -1;
      for (int i = start; i < n; i++) if (m[i] >= thr) begin t = i; break; end
      if (t < 0 || t + PW - 1 > n - 1) break;
      p = t;
      for (int i = t + 1; i < t + PW; i++) if (m[i] > m[p]) p = i;
      e_sf.push_back(t + PW - 1); e_pm.push_back(m[p]); e_po.push_back(p - t);
      j = 0; start = n;
      forever begin
        idx = p + DLY + LEN * j;
        if (idx > n - 1) break;
        if (ns != 0 && j == ns) begin e_fd.push_back(idx); start = idx + 1; break; end
        e_ss.push_back(idx);
        j++;
      end
      if (start >= n) break;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sync_found"}, int'(sync_found), 0);
    chk({tag, "_sym_start"}, int'(sym_start), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_peak_mag"}, int'(peak_mag), 0);
    chk({tag, "_peak_off"}, int'(peak_off), 0);
    en_in = 1'b1; #1;
    chk({tag, "_corr_ena"}, int'(corr_ena), 0);
    en_in = 1'b0;
  endtask

  task automatic check_single(input string tag);
    int exp_ss[$];
    exp_ss = '{357, 677, 997};
    chk({tag, "_sf_count"}, sf_q.size(), 1);
    if (sf_q.size() > 0) begin
      chk({tag, "_sf_idx"}, sf_q[0], 116);
      chk({tag, "_peak_mag"}, pm_q[0], 50);
      chk({tag, "_peak_off"}, po_q[0], 0);
    end
    cmp_q({tag, "_sym"}, ss_q, exp_ss);
  endtask

  task automatic single_stream(input int n);
    fill_base(n, 7'sd3, 7'sd2);
    s_re[101] = 7'sd30; s_im[101] = 7'sd20;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_fd[$];
    int thr, ns, duty, pos;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; en_in = 1'b0;
    thresh = '0; n_sym = '0; CR_in_Re = '0; CR_in_Im = '0; acc = 0; busy_ab = -1;
    repeat (3) step(1'b0, '0, '0, 1'b0);
    check_reset_state("por");
    rst = 1'b0;

    tbl[0] = '{-7'sd64, -7'sd64, 128};
    tbl[1] = '{ 7'sd63, -7'sd64, 127};
    tbl[2] = '{ 7'sd0,   7'sd0,    0};
    tbl[3] = '{-7'sd1,   7'sd1,    2};
    tbl[4] = '{ 7'sd30,  7'sd20,  50};
    tbl[5] = '{-7'sd33,  7'sd17,  50};
    tbl[6] = '{ 7'sd63,  7'sd63, 126};
    tbl[7] = '{-7'sd64,  7'sd0,   64};
    thresh = 8'd0; n_sym = 8'd0;
    for (int v = 0; v < 8; v++) begin
      fill_base(20, tbl[v].re, tbl[v].im);
      start_scn();
      run_stream(20, 1, -1);
      chk($sformatf("tbl%0d_sf_count", v), sf_q.size(), 1);
      if (sf_q.size() > 0) begin
        chk($sformatf("tbl%0d_sf_idx", v), sf_q[0], 15);
        chk($sformatf("tbl%0d_peak_mag", v), pm_q[0], tbl[v].mag);
        chk($sformatf("tbl%0d_peak_off", v), po_q[0], 0);
      end
    end

    thresh = 8'd40; n_sym = 8'd0;
    single_stream(1000);
    start_scn();
    run_stream(1000, 1, -1);
    check_single("single");
    chk("single_busy_track", int'(busy), 1);

    rst = 1'b1; arm = 1'b0;
    repeat (3) step(1'b1, 7'sd3, 7'sd2, 1'b0);
    check_reset_state("midrst");
    rst = 1'b0;
    clr_q();
    repeat (400) step(1'b1, 7'sd3, 7'sd2, 1'b0);
    chk("midrst_no_sym", ss_q.size(), 0);
    chk("midrst_busy", int'(busy), 0);

    start_scn();
    run_stream(1000, 4, -1);
    check_single("duty4");

    fill_base(400, 7'sd3, 7'sd2);
    s_re[101] = 7'sd30;  s_im[101] = 7'sd15;
    s_re[104] = 7'sd40;  s_im[104] = 7'sd20;
    s_re[106] = -7'sd30; s_im[106] = -7'sd30;
    start_scn();
    run_stream(400, 1, -1);
    chk("tie_sf_count", sf_q.size(), 1);
    if (sf_q.size() > 0) begin
      chk("tie_peak_mag", pm_q[0], 60);
      chk("tie_peak_off", po_q[0], 3);
    end
    chk("tie_sym_count", ss_q.size(), 1);
    if (ss_q.size() > 0) chk("tie_first_sym", ss_q[0], 360);

    single_stream(130);
    start_scn();
    busy_ab = -1;
    run_stream(130, 1, 116);
    chk("abort_no_sf", sf_q.size(), 0);
    chk("abort_busy_next", busy_ab, 0);
    chk("abort_busy_end", int'(busy), 0);
    chk("abort_peak_mag_held", int'(peak_mag), 60);
    chk("abort_peak_off_held", int'(peak_off), 3);

    n_sym = 8'd3;
    single_stream(1400);
    start_scn();
    run_stream(1400, 1, -1);
    check_single("nsym3");
    exp_fd = '{1317};
    cmp_q("nsym3_fd", fd_q, exp_fd);
    chk("nsym3_rearm_busy", int'(busy), 1);
    en_in = 1'b1; #1;
    chk("nsym3_rearm_corr_ena", int'(corr_ena), 1);
    en_in = 1'b0;

    for (int r = 0; r < 6; r++) begin
      thr  = int'($urandom_range(20, 90));
      ns   = int'($urandom_range(0, 3));
      duty = int'($urandom_range(1, 2));
      pos  = int'($urandom_range(20, 200));
      for (int i = 0; i <= 1400; i++) begin
        s_re[i] = 7'(int'($urandom_range(0, 16)) - 8);
        s_im[i] = 7'(int'($urandom_range(0, 16)) - 8);
      end
      for (int i = pos; i < pos + 20; i++) begin
        s_re[i] = 7'($urandom);
        s_im[i] = 7'($urandom);
      end
      thresh = 8'(thr); n_sym = 8'(ns);
      model(1400, thr, ns);
      start_scn();
      run_stream(1400, duty, -1);
      cmp_q($sformatf("rnd%0d_sf", r), sf_q, e_sf);
      cmp_q($sformatf("rnd%0d_pmag", r), pm_q, e_pm);
      cmp_q($sformatf("rnd%0d_poff", r), po_q, e_po);
      cmp_q($sformatf("rnd%0d_sym", r), ss_q, e_ss);
      cmp_q($sformatf("rnd%0d_fd", r), fd_q, e_fd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
